menlo_i2s_receiver: RTL
=======================

MENLO_I2S_RECEIVER -- requirements
Module: menlo_i2s_receiver

Interface
REQ-001 Parameter DATA_WIDTH, default 16, bits per channel word.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flops per asynchronous input.
REQ-003 clk  input  1  system clock; the only clock; frequency >= 4x i2s_sclk (e.g. 50 MHz vs 1.536 MHz).
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 i2s_sclk  input  1  serial bit clock from the I2S transmitter; asynchronous to clk.
REQ-006 i2s_lrclk  input  1  word select: 0 = left, 1 = right; asynchronous to clk.
REQ-007 i2s_sdata  input  1  serial data, MSB first; asynchronous to clk.
REQ-008 left_sample  output  DATA_WIDTH  last complete left word.
REQ-009 right_sample  output  DATA_WIDTH  last complete right word.
REQ-010 sample_valid  output  1  one-clk pulse when the left_sample/right_sample pair updates.
REQ-011 frame_error  output  1  one-clk pulse when a channel word ends with fewer than DATA_WIDTH bits.
REQ-012 error_count  output  8  saturating count of frame_error pulses.

Function
REQ-013 Each of i2s_sclk, i2s_lrclk and i2s_sdata SHALL pass through a SYNC_STAGES-flop synchronizer clocked by clk.
REQ-014 An sclk rising edge SHALL be detected as synchronized sclk = 1 with its previous-cycle value = 0; all protocol actions occur only on the clk cycle of a detected edge ("bit event").
REQ-015 On each bit event, the synchronized lrclk and sdata values SHALL be sampled together.
REQ-016 Word boundary: a bit event whose sampled lrclk differs from the lrclk sampled at the previous bit event starts a new word; that bit is the MSB.
REQ-017 State machine SHALL have three states: UNLOCKED (reset state), LEFT, RIGHT.
REQ-018 UNLOCKED: discard all bits; on the first word boundary, go to LEFT if lrclk = 0 or RIGHT if lrclk = 1, and take that bit as the MSB.
REQ-019 LEFT/RIGHT: on a word boundary, go to the state selected by the new lrclk, clear the bit counter, and shift in the MSB.
REQ-020 Shift register: DATA_WIDTH bits, shifted left with sdata entering at the LSB; bit counter saturates at DATA_WIDTH.
REQ-021 Bits after the DATA_WIDTH-th in the same word SHALL be ignored; the word is still valid.
REQ-022 On the bit event that completes the DATA_WIDTH-th bit in LEFT, the word SHALL be latched into a left holding register and left_ok set.
REQ-023 Same event in RIGHT: if left_ok = 1, then on the next clk left_sample <= left hold, right_sample <= completed word, sample_valid = 1 for one clk, and left_ok is cleared; if left_ok = 0, the word is discarded with no pulse.
REQ-024 A word boundary while in LEFT/RIGHT with counter < DATA_WIDTH SHALL pulse frame_error on the next clk, discard the partial word, and clear left_ok.
REQ-025 error_count SHALL increment on each frame_error and hold at 255.
REQ-026 left_sample/right_sample SHALL hold their values between sample_valid pulses.
REQ-027 Simultaneous frame_error and completion cannot occur in one bit event; the boundary takes precedence.

Reset
REQ-028 While reset_n = 0, the following SHALL be held at 0: outputs, synchronizers, shift register, counter, left hold and left_ok; state SHALL be UNLOCKED.
REQ-029 Reset asserted mid-word SHALL abort the word with no sample_valid or frame_error pulse; after release, the block waits for the next word boundary.

Verification
REQ-030 Model transmitter with sclk = 1.536 MHz and clk = 50 MHz sends left 0x1234, right 0xABCD, repeated -> left_sample = 0x1234, right_sample = 0xABCD, exactly one sample_valid per frame, frame_error never asserted.
REQ-031 Release reset mid left word -> no output change until the first full L/R pair; the first sample_valid follows the first complete right word preceded by a complete left word.
REQ-032 Left word truncated to 12 bits -> one frame_error pulse, error_count = 1, no sample_valid for that frame; the next clean frame produces sample_valid.
REQ-033 20-bit words with MSBs 0xBEEF (left) and 0x5555 (right) -> left_sample = 0xBEEF, right_sample = 0x5555, no frame_error.
REQ-034 300 consecutive short words -> error_count saturates at 255 and stays there.
REQ-035 reset_n pulsed low during a right word -> all outputs 0 immediately; normal capture resumes after the next lrclk transition.

Source files
------------

// File: rtl/menlo_i2s_receiver.sv
// I2S receiver: oversamples the asynchronous bit clock, frames left/right words
// on word-select transitions and presents completed L/R pairs with error tracking.
module menlo_i2s_receiver #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i2s_sclk,
    input  logic                  i2s_lrclk,
    input  logic                  i2s_sdata,
    output logic [DATA_WIDTH-1:0] left_sample,
    output logic [DATA_WIDTH-1:0] right_sample,
    output logic                  sample_valid,
    output logic                  frame_error,
    output logic [7:0]            error_count
);

    localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        UNLOCKED,
        LEFT,
        RIGHT
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, lr_sync_q, sd_sync_q;
    logic                   sclk_s, lr_s, sd_s;
    logic                   sclk_prev_q;
    logic                   bit_evt, boundary;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d, shifted;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  left_hold_q, left_hold_d;
    logic                   left_ok_q, left_ok_d;
    logic                   prev_lr_q, prev_lr_d;
    logic                   prev_valid_q, prev_valid_d;
    logic [DATA_WIDTH-1:0]  left_sample_q, left_sample_d;
    logic [DATA_WIDTH-1:0]  right_sample_q, right_sample_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic [7:0]             err_cnt_q, err_cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            lr_sync_q   <= '0;
            sd_sync_q   <= '0;
        end else begin
            sclk_sync_q[0] <= i2s_sclk;
            lr_sync_q[0]   <= i2s_lrclk;
            sd_sync_q[0]   <= i2s_sdata;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sclk_sync_q[i] <= sclk_sync_q[i-1];
                lr_sync_q[i]   <= lr_sync_q[i-1];
                sd_sync_q[i]   <= sd_sync_q[i-1];
            end
        end
    end

    assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
    assign lr_s    = lr_sync_q[SYNC_STAGES-1];
    assign sd_s    = sd_sync_q[SYNC_STAGES-1];
    assign bit_evt = sclk_s & ~sclk_prev_q;
    // The first bit event after reset only records word select, so a reset
    // released mid-word cannot be mistaken for a word boundary.
    assign boundary = bit_evt & prev_valid_q & (lr_s != prev_lr_q);
    assign shifted  = {shift_q[DATA_WIDTH-2:0], sd_s};

    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        cnt_d          = cnt_q;
        left_hold_d    = left_hold_q;
        left_ok_d      = left_ok_q;
        prev_lr_d      = prev_lr_q;
        prev_valid_d   = prev_valid_q;
        left_sample_d  = left_sample_q;
        right_sample_d = right_sample_q;
        valid_d        = 1'b0;
        ferr_d         = 1'b0;
        err_cnt_d      = err_cnt_q;

        if (bit_evt) begin
            prev_lr_d    = lr_s;
            prev_valid_d = 1'b1;
            if (boundary) begin
                if (state_q != UNLOCKED && cnt_q < CNT_FULL) begin
                    ferr_d    = 1'b1;
                    left_ok_d = 1'b0;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
                state_d = lr_s ? RIGHT : LEFT;
                shift_d = shifted;
                cnt_d   = CNT_ONE;
            end else if (state_q != UNLOCKED && cnt_q < CNT_FULL) begin
                shift_d = shifted;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    if (state_q == LEFT) begin
                        left_hold_d = shifted;
                        left_ok_d   = 1'b1;
                    end else if (left_ok_q) begin
                        left_sample_d  = left_hold_q;
                        right_sample_d = shifted;
                        valid_d        = 1'b1;
                        left_ok_d      = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_prev_q    <= 1'b0;
            state_q        <= UNLOCKED;
            shift_q        <= '0;
            cnt_q          <= '0;
            left_hold_q    <= '0;
            left_ok_q      <= 1'b0;
            prev_lr_q      <= 1'b0;
            prev_valid_q   <= 1'b0;
            left_sample_q  <= '0;
            right_sample_q <= '0;
            valid_q        <= 1'b0;
            ferr_q         <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            sclk_prev_q    <= sclk_s;
            state_q        <= state_d;
            shift_q        <= shift_d;
            cnt_q          <= cnt_d;
            left_hold_q    <= left_hold_d;
            left_ok_q      <= left_ok_d;
            prev_lr_q      <= prev_lr_d;
            prev_valid_q   <= prev_valid_d;
            left_sample_q  <= left_sample_d;
            right_sample_q <= right_sample_d;
            valid_q        <= valid_d;
            ferr_q         <= ferr_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign left_sample  = left_sample_q;
    assign right_sample = right_sample_q;
    assign sample_valid = valid_q;
    assign frame_error  = ferr_q;
    assign error_count  = err_cnt_q;

endmodule
